// File: rtl/irq_arbiter.sv
// irq_arbiter: prioritised interrupt arbiter for the pipelined CPU.
//
// Latches peripheral requests as pending, applies a software mask and raises
// one registered irq towards Control. The pipeline's interrupt-taken pulse
// acknowledges it. The in-service source is tracked until the handler writes
// EOI. A short hold-off period then lets the handler's return drain the
// pipeline.
//
// Optional build macro:
//   IRQ_ARB_EDGE_EN  when defined, a source is captured on the rising edge of
//                    its request line.
//                    When undefined, capture is level-sensitive and happens
//                    on every cycle the line is high.
//
// Register map (word offsets from BASE, addr[1:0] ignored):
//   +0x0 PEND   read, write-1-to-clear
//   +0x4 MASK   read/write, 1 enables a source
//   +0x8 CAUSE  read-only {isv_valid[31], isv_id[2:0]}
//   +0xC EOI    any write ends service
//
// Ports:
//   clk       pipeline clock
//   reset     synchronous, active-low reset
//   src_irq   peripheral request lines [NSRC-1:0]
//   ker       CPU in kernel mode; blocks new assertion of irq
//   irq_take  one-cycle pulse: pipeline jumped to the interrupt vector
//   irq       registered interrupt request to Control
//   rd, wr    ME-stage bus read/write strobes
//   addr      bus byte address
//   wdata     bus write data
//   rdata     combinational read data; 0 unless a matching read is active
module irq_arbiter #(
    parameter int          NSRC     = 4,
    parameter int          HOLD_CYC = 3,
    parameter logic [31:0] BASE     = 32'h40000030
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src_irq,
    input  logic            ker,
    input  logic            irq_take,
    output logic            irq,
    input  logic            rd,
    input  logic            wr,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_SERVICE, ST_HOLD} state_t;

    state_t          state;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] mask;
    logic [2:0]      sel_id;
    logic [2:0]      isv_id;
    logic            isv_valid;
    logic [3:0]      hold_cnt;

    logic [NSRC-1:0] cap;
    logic [NSRC-1:0] req;
    logic [NSRC-1:0] sel_oh;
    logic [NSRC-1:0] take_clr;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] pend_nx;
    logic [NSRC-1:0] mask_nx;
    logic [2:0]      low_id;
    logic [29:0]     word_off;
    logic            hit;
    logic            wr_pend;
    logic            wr_mask;
    logic            wr_eoi;
    logic            sel_live;
    logic [31:0]     pend_ext;
    logic [31:0]     mask_ext;
    logic            unused_bus;

    // Low address bits and upper write-data bits carry no information here.
    assign unused_bus = ^{addr[1:0], wdata};

`ifdef IRQ_ARB_EDGE_EN
    // Delayed copy of the request lines so only a rising edge captures.
    logic [NSRC-1:0] src_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            src_q <= '0;
        end else begin
            src_q <= src_irq;
        end
    end

    assign cap = src_irq & ~src_q;
`else
    assign cap = src_irq;
`endif

    // Address decode works on word offsets, so BASE need not be 16-byte aligned.
    always_comb begin
        word_off = addr[31:2] - BASE[31:2];
        hit      = (word_off < 30'd4);
        wr_pend  = wr && hit && (word_off[1:0] == 2'd0);
        wr_mask  = wr && hit && (word_off[1:0] == 2'd1);
        wr_eoi   = wr && hit && (word_off[1:0] == 2'd3);
    end

    // The next pend/mask values are computed ahead of the register update
    // because ASSERT drops back to IDLE at the same edge the selected source
    // loses its pending bit or mask bit. Any capture overrides a clear in the
    // same cycle.
    always_comb begin
        req    = pend & mask;
        low_id = 3'd0;
        sel_oh = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                low_id = 3'(i);
            end
        end
        for (int i = 0; i < NSRC; i++) begin
            sel_oh[i] = (sel_id == 3'(i));
        end
        take_clr = (state == ST_ASSERT && irq_take) ? sel_oh : '0;
        w1c      = wr_pend ? wdata[NSRC-1:0] : '0;
        pend_nx  = (pend & ~w1c & ~take_clr) | cap;
        mask_nx  = wr_mask ? wdata[NSRC-1:0] : mask;
        sel_live = |(pend_nx & mask_nx & sel_oh);
    end

    // Arbitration FSM and register file. irq is a registered copy of
    // "state is ASSERT".
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            irq       <= 1'b0;
            pend      <= '0;
            mask      <= '0;
            sel_id    <= 3'd0;
            isv_id    <= 3'd0;
            isv_valid <= 1'b0;
            hold_cnt  <= 4'd0;
        end else begin
            pend <= pend_nx;
            mask <= mask_nx;
            case (state)
                ST_IDLE: begin
                    if ((|req) && !ker) begin
                        sel_id <= low_id;
                        irq    <= 1'b1;
                        state  <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (irq_take) begin
                        isv_id    <= sel_id;
                        isv_valid <= 1'b1;
                        irq       <= 1'b0;
                        state     <= ST_SERVICE;
                    end else if (!sel_live) begin
                        irq   <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    if (wr_eoi) begin
                        isv_valid <= 1'b0;
                        hold_cnt  <= 4'(HOLD_CYC - 1);
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == 4'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

    // Read mux. It returns 0 during reset, when no read is active, or when the
    // address misses.
    always_comb begin
        rdata    = 32'd0;
        pend_ext = 32'd0;
        mask_ext = 32'd0;
        pend_ext[NSRC-1:0] = pend;
        mask_ext[NSRC-1:0] = mask;
        if (reset && rd && hit) begin
            case (word_off[1:0])
                2'd0:    rdata = pend_ext;
                2'd1:    rdata = mask_ext;
                2'd2:    rdata = {isv_valid, 28'd0, isv_id};
                default: rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed bench for irq_arbiter with the default parameters
// (NSRC=4, HOLD_CYC=3, BASE=32'h40000030).
// Each applyStimulus call holds one set of inputs across exactly one rising
// clock edge. After the edge, outputs are examined 2 ns later.
module tb_irq_arbiter;

    localparam logic [31:0] PEND_A  = 32'h40000030;
    localparam logic [31:0] MASK_A  = 32'h40000034;
    localparam logic [31:0] CAUSE_A = 32'h40000038;
    localparam logic [31:0] EOI_A   = 32'h4000003C;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src_irq;
    logic        ker;
    logic        irq_take;
    logic        irq;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] rv;

    irq_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .src_irq  (src_irq),
        .ker      (ker),
        .irq_take (irq_take),
        .irq      (irq),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata)
    );

    always #5 clk = ~clk;

    // Present one set of inputs for a single rising edge, then return them to idle.
    task automatic applyStimulus(input logic [3:0] s, input logic k, input logic t,
                                 input logic w, input logic [31:0] a, input logic [31:0] d);
        src_irq  = s;
        ker      = k;
        irq_take = t;
        wr       = w;
        addr     = a;
        wdata    = d;
        @(posedge clk);
        #2;
        src_irq  = 4'd0;
        ker      = 1'b0;
        irq_take = 1'b0;
        wr       = 1'b0;
        addr     = 32'd0;
        wdata    = 32'd0;
    endtask

    // Bus read between edges; rdata is combinational.
    task automatic readReg(input logic [31:0] a, output logic [31:0] v);
        rd   = 1'b1;
        addr = a;
        #1;
        v    = rdata;
        rd   = 1'b0;
        addr = 32'd0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Write EOI, then wait long enough for the hold-off period to return the FSM to IDLE.
    task automatic endService();
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1, EOI_A, 32'd0);
        idle(4);
    endtask

`ifdef IRQ_ARB_EDGE_EN
    int takes;
`endif

    initial begin
        reset    = 1'b0;
        src_irq  = 4'd0;
        ker      = 1'b0;
        irq_take = 1'b0;
        rd       = 1'b0;
        wr       = 1'b0;
        addr     = 32'd0;
        wdata    = 32'd0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_irq", irq, 1'b0);
        readReg(CAUSE_A, rv);
        checkOutput("rdata_in_reset", rv, 32'd0);
        reset = 1'b1;
        readReg(PEND_A, rv);  checkOutput("reset_pend", rv, 32'd0);
        readReg(MASK_A, rv);  checkOutput("reset_mask", rv, 32'd0);
        readReg(CAUSE_A, rv); checkOutput("reset_cause", rv, 32'd0);

        // ---- single source, 2-cycle latency ----
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1, MASK_A, 32'h1);
        readReg(MASK_A, rv);  checkOutput("mask_rw", rv, 32'h1);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("lat_edge1_irq", irq, 1'b0);
        readReg(PEND_A, rv);  checkOutput("pend_capture", rv, 32'h1);
        idle(1);
        checkOutput("lat_edge2_irq", irq, 1'b1);
        idle(1);
        checkOutput("irq_held", irq, 1'b1);
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        checkOutput("take0_irq", irq, 1'b0);
        readReg(CAUSE_A, rv); checkOutput("take0_cause", rv, 32'h80000000);
        readReg(PEND_A, rv);  checkOutput("take0_pend", rv, 32'd0);
        readReg(32'h40000040, rv); checkOutput("addr_miss", rv, 32'd0);
        addr = MASK_A; #1;
        checkOutput("rd_low_zero", rdata, 32'd0);
        endService();

        // ---- priority between two sources, EOI hold-off ----
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1, MASK_A, 32'h6);
        applyStimulus(4'b0110, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        idle(1);
        checkOutput("prio_irq", irq, 1'b1);
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        readReg(CAUSE_A, rv); checkOutput("prio_cause1", rv, 32'h80000001);
        readReg(PEND_A, rv);  checkOutput("prio_pend_left", rv, 32'h4);
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        checkOutput("take_in_service_ignored", irq, 1'b0);
        readReg(CAUSE_A, rv); checkOutput("service_cause_kept", rv, 32'h80000001);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1, EOI_A, 32'd0);
        readReg(CAUSE_A, rv); checkOutput("eoi_cause", rv, 32'h00000001);
        for (int i = 1; i <= 3; i++) begin
            idle(1);
            checkOutput($sformatf("hold_irq_w%0d", i), irq, 1'b0);
        end
        idle(1);
        checkOutput("hold_irq_w4", irq, 1'b1);
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        readReg(CAUSE_A, rv); checkOutput("prio_cause2", rv, 32'h80000002);
        readReg(PEND_A, rv);  checkOutput("prio_pend_empty", rv, 32'd0);
        endService();

        // ---- kernel mode blocks new assertion ----
        applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
            checkOutput($sformatf("ker_block_%0d", i), irq, 1'b0);
        end
        idle(1);
        checkOutput("ker_drop_irq", irq, 1'b1);

        // ---- mask clear and take in the same cycle: take wins ----
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b1, MASK_A, 32'h0);
        checkOutput("mask_take_irq", irq, 1'b0);
        readReg(CAUSE_A, rv); checkOutput("mask_take_cause", rv, 32'h80000001);
        readReg(MASK_A, rv);  checkOutput("mask_take_mask", rv, 32'd0);
        endService();

        // ---- mask clear alone drops back to IDLE ----
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1, MASK_A, 32'h2);
        applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        idle(1);
        checkOutput("mask_only_assert", irq, 1'b1);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1, MASK_A, 32'h0);
        checkOutput("mask_only_drop", irq, 1'b0);
        idle(1);
        readReg(CAUSE_A, rv); checkOutput("mask_only_cause", rv, 32'h00000001);
        readReg(PEND_A, rv);  checkOutput("mask_only_pend", rv, 32'h2);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1, MASK_A, 32'h2);
        idle(1);
        checkOutput("mask_only_reassert", irq, 1'b1);
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        endService();

`ifdef IRQ_ARB_EDGE_EN
        // ---- held level produces exactly one service ----
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1, MASK_A, 32'h4);
        takes = 0;
        for (int n = 0; n < 20; n++) begin
            if (irq) begin
                applyStimulus(4'b0100, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
                takes++;
            end else if (n == 10) begin
                applyStimulus(4'b0100, 1'b0, 1'b0, 1'b1, EOI_A, 32'd0);
            end else begin
                applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
            end
        end
        idle(5);
        checkOutput("edge_single_service", takes, 32'd1);
`else
        // ---- W1C while level held has no net effect ----
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b1, PEND_A, 32'h4);
        readReg(PEND_A, rv); checkOutput("level_w1c_held", rv, 32'h4);
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1, PEND_A, 32'h4);
        readReg(PEND_A, rv); checkOutput("level_w1c_clear", rv, 32'd0);
`endif

        // ---- reset while in SERVICE ----
        applyStimulus(4'd0, 1'b0, 1'b0, 1'b1, MASK_A, 32'h1);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        idle(1);
        applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        reset = 1'b0;
        readReg(MASK_A, rv); checkOutput("rdata_gated_by_reset", rv, 32'd0);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b1;
        checkOutput("rst_service_irq", irq, 1'b0);
        readReg(MASK_A, rv);  checkOutput("rst_service_mask", rv, 32'd0);
        readReg(CAUSE_A, rv); checkOutput("rst_service_cause", rv, 32'd0);
        readReg(PEND_A, rv);  checkOutput("rst_service_pend", rv, 32'd0);
        idle(2);
        checkOutput("rst_service_idle_irq", irq, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
